// File: rtl/coord_button_emitter_if.sv
// Bundles the start handshake, the parallel coordinate and the emulated
// button outputs of coord_button_emitter.
//   master : requester side (drives start/abort/x_in/y_in, observes outputs)
//   slave  : emitter side
interface coord_button_emitter_if;
  logic       start;    // request to send x_in/y_in
  logic       abort;    // cancel a sequence in progress
  logic [3:0] x_in;     // X coordinate
  logic [3:0] y_in;     // Y coordinate
  logic       busy;     // sequence in progress
  logic       done;     // one-cycle completion pulse
  logic       btn0_n;   // emulated logic-0 button, active low
  logic       btn1_n;   // emulated logic-1 button, active low
  logic       act_n;    // emulated activity button, active low
  logic [2:0] bit_idx;  // bit currently being sent

  modport master (
    output start, abort, x_in, y_in,
    input  busy, done, btn0_n, btn1_n, act_n, bit_idx
  );

  modport slave (
    input  start, abort, x_in, y_in,
    output busy, done, btn0_n, btn1_n, act_n, bit_idx
  );
endinterface

// File: rtl/coord_button_emitter.sv
// Transmit side of the player coordinate button interface. A coordinate
// accepted on start is replayed as 8 active-low data pulses (x bit0..3, then
// y bit0..3) followed by one activity pulse, each pulse held HOLD_CYCLES and
// separated by GAP_CYCLES of all lines released.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of coord_button_emitter_if (start/abort/x_in/y_in in;
//           busy/done/btn0_n/btn1_n/act_n/bit_idx out, all registered)
module coord_button_emitter #(
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BIT1_ON_BTN0 = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  coord_button_emitter_if.slave  bus
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic          B1_LEVEL  = (BIT1_ON_BTN0 != 0);

  typedef enum logic [2:0] {IDLE, HOLD, GAP, ACT, ACT_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sreg_q, sreg_d;
  logic [2:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          btn0_n_q, btn0_n_d;
  logic          btn1_n_q, btn1_n_d;
  logic          act_n_q, act_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d  = {bus.y_in, bus.x_in};
          idx_d   = '0;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = ACT;
          end else begin
            idx_d   = idx_q + 3'd1;
            sreg_d  = {1'b0, sreg_q[7:1]};
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACT: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ACT_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACT_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    // Lines are decoded from the next state so they are registered yet
    // change on the same edge as the state itself.
    busy_d   = (state_d != IDLE);
    btn0_n_d = !((state_d == HOLD) && (sreg_d[0] == B1_LEVEL));
    btn1_n_d = !((state_d == HOLD) && (sreg_d[0] != B1_LEVEL));
    act_n_d  = !(state_d == ACT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      btn0_n_q <= 1'b1;
      btn1_n_q <= 1'b1;
      act_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      btn0_n_q <= btn0_n_d;
      btn1_n_q <= btn1_n_d;
      act_n_q  <= act_n_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.btn0_n  = btn0_n_q;
  assign bus.btn1_n  = btn1_n_q;
  assign bus.act_n   = act_n_q;
  assign bus.bit_idx = idx_q;

endmodule

// File: tb/tb_coord_button_emitter.sv
// Directed bench for coord_button_emitter: default instance (4/2/1) and a
// fast variant (1/1/0). Observed vector is {busy,done,btn0_n,btn1_n,act_n,bit_idx}.
module tb_coord_button_emitter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coord_button_emitter_if ia ();
  coord_button_emitter_if ib ();

  coord_button_emitter u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  coord_button_emitter #(
    .HOLD_CYCLES  (1),
    .GAP_CYCLES   (1),
    .BIT1_ON_BTN0 (0)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k edges after the start-sampling edge.
  function automatic logic [7:0] model(input int k, input int h, input int g,
                                       input int b1, input logic [7:0] c);
    int p, b, ph;
    logic l0, l1, la;
    logic [2:0] ix;
    p = h + g;
    if (k > 9 * p)  return {2'b00, 3'b111, 3'd7};
    if (k == 9 * p) return {2'b01, 3'b111, 3'd7};
    b  = k / p;
    ph = k % p;
    l0 = 1'b1; l1 = 1'b1; la = 1'b1;
    ix = (b < 8) ? 3'(b) : 3'd7;
    if (ph < h) begin
      if (b == 8)              la = 1'b0;
      else if (c[b] == b1[0])  l0 = 1'b0;
      else                     l1 = 1'b0;
    end
    return {2'b10, l0, l1, la, ix};
  endfunction

  function automatic logic [7:0] obs_a();
    return {ia.busy, ia.done, ia.btn0_n, ia.btn1_n, ia.act_n, ia.bit_idx};
  endfunction

  function automatic logic [7:0] obs_b();
    return {ib.busy, ib.done, ib.btn0_n, ib.btn1_n, ib.act_n, ib.bit_idx};
  endfunction

  int  done_cnt;
  logic seen_done, seen_low, seen_busy;

  initial begin
    ia.start = 1'b0; ia.abort = 1'b0; ia.x_in = '0; ia.y_in = '0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.x_in = '0; ib.y_in = '0;
    reset = 1'b1;
    tick(); tick();
    chk("reset_a", 32'(obs_a()), 32'h38);
    chk("reset_b", 32'(obs_b()), 32'h38);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 32'(obs_a()), 32'h38);

    // Basic send x=A y=3, then back-to-back x=F y=0 from the done cycle.
    ia.x_in = 4'hA; ia.y_in = 4'h3; ia.start = 1'b1;
    tick();
    ia.start = 1'b0; ia.x_in = 4'h0; ia.y_in = 4'hF;
    chk("basic_first_btn1", 32'(ia.btn1_n), 32'd0);
    for (int k = 0; k <= 54; k++) begin
      chk($sformatf("basic_k%0d", k), 32'(obs_a()), 32'(model(k, 4, 2, 1, 8'h3A)));
      if (k == 54) begin
        chk("basic_done54", 32'(ia.done), 32'd1);
        ia.start = 1'b1; ia.x_in = 4'hF; ia.y_in = 4'h0;
      end
      tick();
    end
    ia.start = 1'b0;
    for (int k = 0; k <= 55; k++) begin
      chk($sformatf("b2b_k%0d", k), 32'(obs_a()), 32'(model(k, 4, 2, 1, 8'h0F)));
      if (k < 55) tick();
    end

    // Start while busy must be ignored.
    ia.x_in = 4'hC; ia.y_in = 4'h6; ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k <= 55; k++) begin
      chk($sformatf("busy_start_k%0d", k), 32'(obs_a()), 32'(model(k, 4, 2, 1, 8'h6C)));
      done_cnt += int'(ia.done);
      if (k == 10) begin ia.start = 1'b1; ia.x_in = 4'h5; end
      if (k == 11) ia.start = 1'b0;
      if (k < 55) tick();
    end
    chk("busy_start_done_count", 32'(done_cnt), 32'd1);

    // Abort during the gap after bit 3.
    ia.x_in = 4'h7; ia.y_in = 4'h9; ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      chk($sformatf("abort_k%0d", k), 32'(obs_a()), 32'(model(k, 4, 2, 1, 8'h97)));
      if (k < 22) tick();
    end
    ia.abort = 1'b1;
    tick();
    ia.abort = 1'b0;
    chk("abort_next", 32'(obs_a()), 32'h3B);
    seen_done = 1'b0; seen_low = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      seen_done |= ia.done;
      seen_busy |= ia.busy;
      seen_low  |= ~(ia.btn0_n & ia.btn1_n & ia.act_n);
    end
    chk("abort_quiet", 32'({seen_done, seen_busy, seen_low}), 32'd0);

    // abort in IDLE together with start: start wins.
    ia.x_in = 4'h2; ia.y_in = 4'h4; ia.start = 1'b1; ia.abort = 1'b1;
    tick();
    ia.start = 1'b0; ia.abort = 1'b0;
    chk("start_wins_k0", 32'(obs_a()), 32'(model(0, 4, 2, 1, 8'h42)));
    tick();
    chk("start_wins_k1", 32'(obs_a()), 32'(model(1, 4, 2, 1, 8'h42)));

    // Asynchronous reset mid-HOLD.
    #2 reset = 1'b1;
    #1 chk("reset_mid_hold", 32'(obs_a()), 32'h38);
    tick();
    reset = 1'b0;
    seen_done = 1'b0; seen_low = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      seen_done |= ia.done;
      seen_busy |= ia.busy;
      seen_low  |= ~(ia.btn0_n & ia.btn1_n & ia.act_n);
    end
    chk("reset_quiet", 32'({seen_done, seen_busy, seen_low}), 32'd0);

    // Variant: 1/1 timing, swapped mapping, x=1 y=8.
    ib.x_in = 4'h1; ib.y_in = 4'h8; ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    chk("var_first_btn1", 32'({ib.btn0_n, ib.btn1_n}), 32'b10);
    for (int k = 0; k <= 19; k++) begin
      chk($sformatf("var_k%0d", k), 32'(obs_b()), 32'(model(k, 1, 1, 0, 8'h81)));
      if (k == 18) chk("var_done18", 32'(ib.done), 32'd1);
      if (k < 19) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
